// File: rtl/qam_pkg.sv
// qam_pkg: carrier LUT, level type/map and output scaling shared by qam16_top.
// QAM_GRAY_MAP_EN selects the Gray level map; otherwise the natural binary map is used.
package qam_pkg;
  localparam int OUT_W = 18;
  localparam int DEMULT_SHIFT = 8;
  typedef logic signed [2:0] level_t;
  typedef logic signed [11:0] carrier_t;
  localparam carrier_t SIN_LUT [16] = '{
    12'sd0, 12'sd783, 12'sd1447, 12'sd1891, 12'sd2047, 12'sd1891, 12'sd1447, 12'sd783,
    12'sd0, -12'sd783, -12'sd1447, -12'sd1891, -12'sd2047, -12'sd1891, -12'sd1447, -12'sd783
  };
  // For a binary index b, {~b[1], b[0], 1} is 2b-3 in 3-bit two's complement.
  function automatic level_t level_map(input logic [1:0] f);
`ifdef QAM_GRAY_MAP_EN
    return level_t'({~f[1], f[1] ^ f[0], 1'b1});
`else
    return level_t'({~f[1], f[0], 1'b1});
`endif
  endfunction
endpackage

// File: rtl/qam_nco.sv
// qam_nco: registered cos/sin carrier lookup, one carrier cycle per symbol period.
module qam_nco
  import qam_pkg::*;
#(
  parameter int SPS = 16
) (
  input  logic                   axi_clk,
  input  logic                   axi_rst,
  input  logic [$clog2(SPS)-1:0] cnt,
  output carrier_t               cos_val,
  output carrier_t               sin_val
);
  logic [3:0] k, kc;
  assign k  = cnt[$clog2(SPS)-1 -: 4];
  assign kc = k + 4'd4;
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      cos_val <= '0;
      sin_val <= '0;
    end else begin
      cos_val <= SIN_LUT[kc];
      sin_val <= SIN_LUT[k];
    end
  end
endmodule

// File: rtl/qam16_top.sv
// qam16_top: 16-QAM map, carrier modulation and coherent demix to raw I/Q baseband.
// Level map chosen by QAM_GRAY_MAP_EN (see qam_pkg).
module qam16_top
  import qam_pkg::*;
#(
  parameter int SPS = 16
) (
  input  logic                    axi_clk,
  input  logic                    axi_rst,
  input  logic                    din_valid,
  input  logic [3:0]              din,
  output logic                    din_ready,
  output logic                    demult_valid,
  output logic signed [OUT_W-1:0] demult_i,
  output logic signed [OUT_W-1:0] demult_q
);
  localparam int CW = $clog2(SPS);
  logic [CW-1:0] cnt;
  logic [3:0] sym, sym_d;
  logic tag, tag_d;
  logic [3:0] vp;
  carrier_t cos_n, sin_n, cos_a, sin_a, cos_b, sin_b, cos_c, sin_c;
  level_t lvl_i, lvl_q;
  logic signed [14:0] pi_b, pq_b;
  logic signed [15:0] s_c;
  logic signed [27:0] mi_d, mq_d;
  assign din_ready = cnt == CW'(SPS - 1);
  qam_nco #(.SPS(SPS)) u_nco (
    .axi_clk (axi_clk),
    .axi_rst (axi_rst),
    .cnt     (cnt),
    .cos_val (cos_n),
    .sin_val (sin_n)
  );
  // sym_d/tag_d delay the held symbol by one so it lines up with the registered carrier
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      cnt          <= '0;
      sym          <= '0;
      tag          <= 1'b0;
      sym_d        <= '0;
      tag_d        <= 1'b0;
      vp           <= '0;
      lvl_i        <= '0;
      lvl_q        <= '0;
      cos_a        <= '0;
      sin_a        <= '0;
      pi_b         <= '0;
      pq_b         <= '0;
      cos_b        <= '0;
      sin_b        <= '0;
      s_c          <= '0;
      cos_c        <= '0;
      sin_c        <= '0;
      mi_d         <= '0;
      mq_d         <= '0;
      demult_valid <= 1'b0;
      demult_i     <= '0;
      demult_q     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (din_ready) begin
        sym <= din_valid ? din : 4'd0;
        tag <= din_valid;
      end
      sym_d        <= sym;
      tag_d        <= tag;
      lvl_i        <= tag_d ? level_map(sym_d[3:2]) : level_t'(0);
      lvl_q        <= tag_d ? level_map(sym_d[1:0]) : level_t'(0);
      cos_a        <= cos_n;
      sin_a        <= sin_n;
      vp           <= {vp[2:0], tag_d};
      pi_b         <= 15'(lvl_i) * 15'(cos_a);
      pq_b         <= 15'(lvl_q) * 15'(sin_a);
      cos_b        <= cos_a;
      sin_b        <= sin_a;
      s_c          <= 16'(pi_b) - 16'(pq_b);
      cos_c        <= cos_b;
      sin_c        <= sin_b;
      mi_d         <= 28'(s_c) * 28'(cos_c);
      mq_d         <= 28'(s_c) * 28'(sin_c);
      demult_valid <= vp[3];
      demult_i     <= OUT_W'(mi_d >>> DEMULT_SHIFT);
      demult_q     <= OUT_W'((-mq_d) >>> DEMULT_SHIFT);
    end
  end
endmodule

// File: tb/tb_qam16_top.sv
// tb_qam16_top: randomized stimulus against an arithmetic reference of qam16_top.
module tb_qam16_top;
  localparam int N = 32768;
  logic axi_clk = 1'b0;
  logic axi_rst = 1'b1;
  logic din_valid = 1'b0;
  logic [3:0] din = 4'd0;
  logic din_ready, demult_valid;
  logic signed [17:0] demult_i, demult_q;
  int total = 0, bad = 0, cyc = 0, rel = 0;
  bit chk_on = 1'b0, exp_rdy = 1'b0;
  bit exp_v [N];
  int exp_i [N];
  int exp_q [N];
  int hi_run = 0, lo_run = 0, last_hi = 0, last_lo = 0;
`ifdef QAM_GRAY_MAP_EN
  localparam logic [3:0] SYM_P3 = 4'b1010;
`else
  localparam logic [3:0] SYM_P3 = 4'b1111;
`endif

  qam16_top #(.SPS(16)) dut (
    .axi_clk      (axi_clk),
    .axi_rst      (axi_rst),
    .din_valid    (din_valid),
    .din          (din),
    .din_ready    (din_ready),
    .demult_valid (demult_valid),
    .demult_i     (demult_i),
    .demult_q     (demult_q)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(input string nm, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  function automatic int lev(input logic [1:0] f);
`ifdef QAM_GRAY_MAP_EN
    return f == 2'b00 ? -3 : f == 2'b01 ? -1 : f == 2'b11 ? 1 : 3;
`else
    return f == 2'b00 ? -3 : f == 2'b01 ? -1 : f == 2'b10 ? 1 : 3;
`endif
  endfunction

  function automatic int sn(input int k);
    return int'($floor(2047.0 * $sin(2.0 * 3.14159265358979 * k / 16.0) + 0.5));
  endfunction

  function automatic longint fdiv256(input longint a);
    return a >= 0 ? a / 256 : -((-a + 255) / 256);
  endfunction

  // reference model: stamps the 16 expected samples of every accepted symbol into time slots
  always @(posedge axi_clk) begin
    cyc++;
    if (axi_rst) begin
      rel = 0;
      for (int j = 0; j < 24; j++)
        if (cyc + j < N) begin
          exp_v[cyc+j] = 1'b0;
          exp_i[cyc+j] = 0;
          exp_q[cyc+j] = 0;
        end
    end else begin
      if (rel % 16 == 15 && din_valid)
        for (int k = 0; k < 16; k++) begin
          longint s;
          s = longint'(lev(din[3:2])) * sn((k + 4) % 16) - longint'(lev(din[1:0])) * sn(k);
          if (cyc + 6 + k < N) begin
            exp_v[cyc+6+k] = 1'b1;
            exp_i[cyc+6+k] = int'(fdiv256(s * sn((k + 4) % 16)));
            exp_q[cyc+6+k] = int'(fdiv256(-(s * sn(k))));
          end
        end
      rel++;
    end
    exp_rdy = !axi_rst && rel % 16 == 15;
  end

  always @(negedge axi_clk) begin
    if (chk_on && cyc < N) begin
      chk("din_ready", din_ready, exp_rdy);
      chk("demult_valid", demult_valid, exp_v[cyc]);
      chk("demult_i", demult_i, exp_i[cyc]);
      chk("demult_q", demult_q, exp_q[cyc]);
    end
    if (demult_valid === 1'b1) begin
      if (lo_run > 0) last_lo = lo_run;
      lo_run = 0;
      hi_run++;
    end else begin
      if (hi_run > 0) last_hi = hi_run;
      hi_run = 0;
      lo_run++;
    end
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic send(input bit v, input logic [3:0] d);
    int n = 0;
    while (!exp_rdy && n < 40) begin
      din_valid = 1'($urandom);
      din = 4'($urandom);
      tick();
      n++;
    end
    if (n >= 40) chk("ready wait timeout", 0, 1);
    din_valid = v;
    din = d;
    tick();
    din_valid = 1'b0;
    din = 4'($urandom);
  endtask

  task automatic release_check(input string nm);
    int first = 0, pulses = 0, highs = 0;
    axi_rst = 1'b0;
    din_valid = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      tick();
      if (din_ready && first == 0) first = n;
      pulses += int'(din_ready);
      highs += int'(demult_valid);
    end
    chk({nm, " first ready edge"}, first, 15);
    chk({nm, " ready pulses"}, pulses, 4);
    chk({nm, " valid after reset"}, highs, 0);
  endtask

  initial begin
    int ta;
    tick();
    chk_on = 1'b1;
    tick();
    chk("reset din_ready", din_ready, 0);
    chk("reset demult_valid", demult_valid, 0);
    chk("reset demult_i", demult_i, 0);
    release_check("initial");

    send(1'b1, SYM_P3);
    ta = cyc;
    chk("model +3 s0 i", exp_i[ta+6], 49104);
    chk("model +3 s4 q", exp_q[ta+10], 49104);
    repeat (5) tick();
    chk("+3 pre valid", demult_valid, 0);
    tick();
    chk("+3 s0 valid", demult_valid, 1);
    chk("+3 s0 i", demult_i, 49104);
    chk("+3 s0 q", demult_q, 0);
    repeat (4) tick();
    chk("+3 s4 i", demult_i, 0);
    chk("+3 s4 q", demult_q, 49104);
    repeat (30) tick();
    chk("+3 valid length", last_hi, 16);

    send(1'b1, 4'b0000);
    ta = cyc;
    chk("model -3 s0 i", exp_i[ta+6], -49105);
    repeat (6) tick();
    chk("-3 s0 i", demult_i, -49105);
    chk("-3 s0 q", demult_q, 0);
    repeat (30) tick();

    for (int r = 0; r < 1024; r++) send(1'b1, 4'($urandom_range(0, 15)));
    repeat (30) tick();
    chk("random valid run", last_hi, 1024 * 16);

    for (int r = 0; r < 3; r++) send(1'b1, 4'($urandom));
    send(1'b0, 4'($urandom));
    for (int r = 0; r < 3; r++) send(1'b1, 4'($urandom));
    repeat (3) tick();
    chk("gap low length", last_lo, 16);
    repeat (30) tick();

    send(1'b1, 4'($urandom));
    repeat (13) tick();
    chk("pre-reset sample7 valid", demult_valid, 1);
    axi_rst = 1'b1;
    tick();
    chk("mid reset valid", demult_valid, 0);
    chk("mid reset i", demult_i, 0);
    chk("mid reset q", demult_q, 0);
    chk("mid reset ready", din_ready, 0);
    release_check("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
